// File: rtl/mtl_sopc_cpu_oci_dct_packer.sv
// DCT packer for the MTL_SOPC CPU on-chip-debug trace path.
// Packs 2-bit trace codes into a 15-slot buffer and hands full or flushed
// buffers to a single-entry valid/ready output stage. It also sequences the
// end-of-test drain (ACTIVE -> ENDING -> ENDED).
// Optional build macro: MTL_SOPC_DCT_DROP_COUNT_EN enables the saturating
// dropped-code counter on drop_count. Without it, drop_count is tied to 0.
module mtl_sopc_cpu_oci_dct_packer #(
    parameter int SLOTS = 15,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               code_valid,
    input  logic [1:0]         code,
    input  logic               flush,
    input  logic               test_ending,
    input  logic               pkt_ready,
    output logic [2*SLOTS-1:0] dct_buffer,
    output logic [CNT_W-1:0]   dct_count,
    output logic               pkt_valid,
    output logic [2*SLOTS-1:0] pkt_data,
    output logic [CNT_W-1:0]   pkt_count,
    output logic               overflow,
    output logic               test_has_ended,
    output logic [7:0]         drop_count
);

    localparam int               BUF_W = 2 * SLOTS;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(SLOTS);

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_ENDING,
        ST_ENDED
    } state_t;

    state_t             state_q, state_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pkt_valid_q, pkt_valid_d;
    logic [BUF_W-1:0]   pkt_data_q, pkt_data_d;
    logic [CNT_W-1:0]   pkt_count_q, pkt_count_d;
    logic               pending_q, pending_d;
    logic               overflow_q, overflow_d;
    logic               ended_q, ended_d;

    logic               stage_free;
    logic               accept;
    logic               flush_req;
    logic               drop;
    logic [BUF_W-1:0]   merged_buf;
    logic [CNT_W-1:0]   merged_cnt;

    // Buffer, output stage and pending-flush next state for one cycle.
    always_comb begin
        stage_free  = !pkt_valid_q || pkt_ready;
        accept      = code_valid && (state_q == ST_ACTIVE);
        flush_req   = flush || pending_q || ((state_q == ST_ACTIVE) && test_ending);
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        pkt_valid_d = pkt_valid_q && !pkt_ready;
        pkt_data_d  = pkt_data_q;
        pkt_count_d = pkt_count_q;
        pending_d   = pending_q;
        drop        = 1'b0;
        merged_buf  = buf_q;
        merged_cnt  = cnt_q;
        if (cnt_q == FULL) begin
            if (stage_free) begin
                pkt_valid_d = 1'b1;
                pkt_data_d  = buf_q;
                pkt_count_d = FULL;
                buf_d       = '0;
                cnt_d       = '0;
                if (accept) begin
                    buf_d = {{(BUF_W-2){1'b0}}, code};
                    cnt_d = CNT_W'(1);
                end
                pending_d = flush_req && accept;
            end else begin
                drop      = accept;
                pending_d = flush_req;
            end
        end else begin
            if (accept) begin
                merged_buf = buf_q | (BUF_W'(code) << {cnt_q, 1'b0});
                merged_cnt = cnt_q + 1'b1;
            end
            buf_d = merged_buf;
            cnt_d = merged_cnt;
            if (((merged_cnt == FULL) || (flush_req && (merged_cnt != '0))) && stage_free) begin
                pkt_valid_d = 1'b1;
                pkt_data_d  = merged_buf;
                pkt_count_d = merged_cnt;
                buf_d       = '0;
                cnt_d       = '0;
                pending_d   = 1'b0;
            end else if (merged_cnt == FULL) begin
                pending_d = flush_req;
            end else begin
                pending_d = flush_req && (merged_cnt != '0);
            end
        end
        overflow_d = overflow_q || drop;
    end

    // End-of-test sequencing; ENDED is terminal until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACTIVE: if (test_ending) state_d = ST_ENDING;
            ST_ENDING: if ((cnt_q == '0) && !pending_q && !pkt_valid_q) state_d = ST_ENDED;
            default:   state_d = ST_ENDED;
        endcase
        ended_d = ended_q || (state_d == ST_ENDED);
    end

    // Register all state; async active-low reset returns everything to idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_ACTIVE;
            buf_q       <= '0;
            cnt_q       <= '0;
            pkt_valid_q <= 1'b0;
            pkt_data_q  <= '0;
            pkt_count_q <= '0;
            pending_q   <= 1'b0;
            overflow_q  <= 1'b0;
            ended_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_data_q  <= pkt_data_d;
            pkt_count_q <= pkt_count_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            ended_q     <= ended_d;
        end
    end

`ifdef MTL_SOPC_DCT_DROP_COUNT_EN
    logic [7:0] drop_count_q, drop_count_d;

    // Saturating count of dropped codes.
    always_comb begin
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != 8'hFF)) drop_count_d = drop_count_q + 8'd1;
    end

    // Drop counter register; only reset clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) drop_count_q <= '0;
        else          drop_count_q <= drop_count_d;
    end

    assign drop_count = drop_count_q;
`else
    assign drop_count = '0;
`endif

    assign dct_buffer     = buf_q;
    assign dct_count      = cnt_q;
    assign pkt_valid      = pkt_valid_q;
    assign pkt_data       = pkt_data_q;
    assign pkt_count      = pkt_count_q;
    assign overflow       = overflow_q;
    assign test_has_ended = ended_q;

endmodule
